// File: rtl/nibble_serial_adder.sv
// Serial wide adder: walks two WIDTH-bit operands through an external 4-bit
// ripple-carry slice one nibble per clock and returns the result on valid/ready.
module nibble_serial_adder #(
  parameter int WIDTH = 16  // multiple of 4, at least 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [3:0]       add_a,
  output logic [3:0]       add_b,
  output logic             add_cin,
  input  logic [3:0]       add_sum,
  input  logic             add_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never depends on ready, and in_ready/out_valid are pure
  // functions of the registered state.

  localparam int NIB  = WIDTH / 4;
  localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(NIB - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [IDXW-1:0]  r_idx;
  logic             r_carry;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;

  logic             w_accept;
  logic             w_run;
  logic             w_last;
  logic [IDXW+1:0]  w_base;

  assign w_accept = in_valid && (r_state == S_IDLE);
  assign w_run    = (r_state == S_RUN);
  assign w_last   = (r_idx == LAST);
  assign w_base   = {r_idx, 2'b00};

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid)  w_next = S_RUN;
      S_RUN:   if (w_last)    w_next = S_DONE;
      S_DONE:  if (out_ready) w_next = S_IDLE;
      default:                w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= b;
      r_carry <= cin;
      r_idx   <= '0;
      r_sum   <= '0;
    end else if (w_run) begin
      r_sum[w_base +: 4] <= add_sum;
      r_carry            <= add_cout;
      if (w_last) begin
        r_idx  <= '0;
        r_cout <= add_cout;
        // add_sum[3] is the MSB of the final sum, written this same edge.
        r_ovf  <= (r_a[WIDTH-1] == r_b[WIDTH-1]) && (add_sum[3] != r_a[WIDTH-1]);
      end else begin
        r_idx <= r_idx + IDXW'(1);
      end
    end
  end

  assign add_a     = w_run ? r_a[w_base +: 4] : 4'd0;
  assign add_b     = w_run ? r_b[w_base +: 4] : 4'd0;
  assign add_cin   = w_run ? r_carry : 1'b0;

  assign in_ready  = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Bench for nibble_serial_adder: behavioural slice adder, arithmetic reference
// model, expected-result queue popped by an output monitor.
module tb_nibble_serial_adder;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic [3:0]   add_a, add_b, add_sum;
  logic         add_cin, add_cout;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] sum;
  logic         cout, ovf, busy;
  logic [1:0]   dbg_state;

  int n_vec = 0;
  int n_err = 0;
  logic [W+1:0] exp_q[$];  // {ovf, cout, sum}
  bit or_force_lo = 1'b0;
  bit or_rand     = 1'b0;

  nibble_serial_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .busy(busy), .dbg_state(dbg_state)
  );

  // The existing 4-bit slice, modelled behaviourally.
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_cin};

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [W+1:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic c);
    int s_u, s_s;
    logic [W:0] full;
    logic ov;
    s_u  = int'(x) + int'(y) + int'(c);
    s_s  = int'($signed(x)) + int'($signed(y)) + int'(c);
    full = (W+1)'(s_u);
    ov   = (s_s > 32767) || (s_s < -32768);
    return {ov, full};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- out_ready driver ----------------
  initial forever begin
    @(posedge clk);
    #1;
    if (or_force_lo)  out_ready = 1'b0;
    else if (or_rand) out_ready = 1'($urandom_range(0, 1));
    else              out_ready = 1'b1;
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_result: got 0x%0h with empty queue, expected no result",
                 {ovf, cout, sum});
      end else begin
        logic [W+1:0] e;
        e = exp_q.pop_front();
        chk("result{ovf,cout,sum}", {14'b0, ovf, cout, sum}, {14'b0, e});
      end
    end
  end

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic send(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc,
                      input bit push);
    int t = 0;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) chk("accept_timeout_in_ready", {31'b0, in_ready}, 32'd1);
    a = xa; b = xb; cin = xc; in_valid = 1'b1;
    if (push) exp_q.push_back(ref_add(xa, xb, xc));
    @(negedge clk);
    in_valid = 1'b0;
    a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom_range(0, 1));
  endtask

  // Checks slice drive and carry chain each RUN cycle, then the 4-cycle latency.
  task automatic dir_run(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc,
                         input logic [3:0] exp_cin);
    send(xa, xb, xc, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("add_a_c%0d", i + 1), {28'b0, add_a}, {28'b0, xa[i*4 +: 4]});
      chk($sformatf("add_b_c%0d", i + 1), {28'b0, add_b}, {28'b0, xb[i*4 +: 4]});
      chk($sformatf("add_cin_c%0d", i + 1), {31'b0, add_cin}, {31'b0, exp_cin[i]});
      chk($sformatf("out_valid_low_c%0d", i + 1), {31'b0, out_valid}, 32'd0);
      @(negedge clk);
    end
    chk("latency_out_valid", {31'b0, out_valid}, 32'd1);
    @(negedge clk);
    chk("out_valid_drop", {31'b0, out_valid}, 32'd0);
    chk("in_ready_after_done", {31'b0, in_ready}, 32'd1);
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("drain_queue_size", exp_q.size(), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [W+1:0] bp_exp;
    int t;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    chk("rst_in_ready",  {31'b0, in_ready},  32'd1);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_busy",      {31'b0, busy},      32'd0);
    chk("rst_sum",       {16'b0, sum},       32'd0);
    chk("rst_cout_ovf",  {30'b0, cout, ovf}, 32'd0);
    chk("rst_add_drive", {23'b0, add_a, add_b, add_cin}, 32'd0);
    chk("rst_state",     {30'b0, dbg_state}, 32'd0);

    dir_run(16'h1234, 16'h4321, 1'b0, 4'b0000);
    dir_run(16'hFFFF, 16'h0001, 1'b0, 4'b1110);
    dir_run(16'h7FFF, 16'h0001, 1'b0, 4'b1110);
    dir_run(16'h8000, 16'h8000, 1'b0, 4'b0000);
    dir_run(16'hFFFF, 16'hFFFF, 1'b1, 4'b1111);

    // Backpressure with an ignored second request.
    or_force_lo = 1'b1;
    @(negedge clk);
    bp_exp = ref_add(16'h0F0F, 16'h00F1, 1'b0);
    send(16'h0F0F, 16'h00F1, 1'b0, 1'b1);
    t = 0;
    while (!out_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    for (int i = 0; i < 5; i++) begin
      chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
      chk("bp_sum_stable", {16'b0, sum}, {16'b0, bp_exp[W-1:0]});
      chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
      if (i == 1) begin
        a = 16'h1111; b = 16'h2222; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    or_force_lo = 1'b0;
    t = 0;
    while (out_valid && t < 10) begin
      @(negedge clk);
      t++;
    end
    chk("bp_release_out_valid", {31'b0, out_valid}, 32'd0);
    chk("bp_release_in_ready", {31'b0, in_ready}, 32'd1);
    send(16'h1111, 16'h2222, 1'b0, 1'b1);
    drain();

    // Asynchronous reset during the second RUN cycle.
    send(16'hAAAA, 16'h5555, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("arst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("arst_sum",       {16'b0, sum},       32'd0);
    chk("arst_busy",      {31'b0, busy},      32'd0);
    chk("arst_in_ready",  {31'b0, in_ready},  32'd1);
    chk("arst_cout_ovf",  {30'b0, cout, ovf}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send(16'h0003, 16'h0004, 1'b0, 1'b1);
    drain();

    // Randomised operands with random output backpressure.
    or_rand = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      send(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'b1);
      if ($urandom_range(0, 7) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    drain();
    or_rand = 1'b0;
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
